elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  Single-car elevator scheduler for FLOORS floors. Latches floor call buttons, moves the car one floor per
//  MOVE_TICKS cycles using SCAN ordering (finish current direction, then reverse), holds door open DOOR_TICKS.
//  Drives elev_f_o (floor 1..FLOORS, binary) straight into hex_controller; sole owner of the car position.
// PARAMETERS
//  FLOORS      7    number of floors, 2..7 (elev_f_o is 3 bits, floor 0 never used)
//  MOVE_TICKS  50   clk cycles to travel one floor, >=1
//  DOOR_TICKS  100  clk cycles door stays open, >=1
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  call_i       in   FLOORS  call buttons, bit k = floor k+1, level or pulse, sampled every cycle
//  elev_f_o     out  3       current car floor, 1..FLOORS
//  dir_o        out  2       01 moving up, 10 moving down, 00 stationary (idle or door open)
//  door_open_o  out  1       1 while in DOOR state
//  pending_o    out  FLOORS  latched unserved calls
//  busy_o       out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): elev_f_o=1, dir_o=00, door_open_o=0, pending_o=0, busy_o=0, state IDLE,
//   last_dir=UP, timers=0. Reset mid-move/mid-door aborts immediately; calls are lost.
//  Call latch: pending <= (pending | call_i) & ~clear each cycle; clear wins over a same-cycle call at that floor.
//  States: IDLE, UP, DOWN, DOOR. above = any pending bit above car floor, below = any below.
//  IDLE: pending at car floor -> DOOR next cycle, clear that bit.
//   else above&&below -> go last_dir; else above -> UP; else below -> DOWN; else stay.
//  UP/DOWN: counter runs 0..MOVE_TICKS-1; on terminal count floor +/-1 same edge, counter->0.
//   New floor pending -> DOOR (clear bit, last_dir kept); else keep moving (calls lie further ahead).
//   Calls for the floor being left are latched, served later; never stop between floors.
//  DOOR: door_open_o=1, counter runs DOOR_TICKS cycles. Call at car floor during DOOR -> bit cleared,
//   door counter restarts at 0. On expiry: calls ahead in last_dir -> continue; else calls behind ->
//   reverse (last_dir flips); else IDLE. Total door time = DOOR_TICKS cycles after last restart.
//  Latency: IDLE call at same floor -> door_open_o high 1 cycle after call sampled. Call one floor up
//   from IDLE -> elev_f_o increments MOVE_TICKS+1 cycles after call, door opens same edge.
//  Bounds: floor never <1 or >FLOORS; UP never entered at FLOORS, DOWN never at 1 (above/below false).
//  Counters sized $clog2(max(MOVE_TICKS,DOOR_TICKS)+1); no wrap, cleared on every state change.
//  All outputs registered; dir_o/busy_o/door_open_o decoded from state register.
// CONFIGURATION
//  ELEV_EMERGENCY_STOP_EN defined: adds input stop_i (1 bit). While stop_i=1 move and door counters freeze,
//   state and floor hold, calls still latch; door stays as is. Release resumes exactly where frozen.
//  Not defined: no stop_i port; behaviour identical to stop_i tied 0.
// TESTING (bench params FLOORS=7, MOVE_TICKS=4, DOOR_TICKS=3)
//  Reset: hold rst_n=0 async mid-cycle -> elev_f_o=1, dir_o=00, pending_o=0 immediately, no clk needed.
//  Call floor1 pulse at idle -> door_open_o=1 next cycle for 3 cycles, pending_o[0] cleared, back to IDLE.
//  Call floor4 from floor1 -> dir_o=01, elev_f_o 2,3,4 every 4 cycles, door opens at 4, then IDLE dir_o=00.
//  SCAN: at floor4 moving up, calls 6 and 2 -> stops 6 then reverses, stops 2; floor 5 passed without stop.
//  Door retrigger: call floor4 on cycle 2 of door at 4 -> door stays open 3 more cycles, bit never set.
//  ELEV_EMERGENCY_STOP_EN: stop_i=1 for 10 cycles mid-move -> elev_f_o and counter frozen, resumes after.

Source files
------------

// File: rtl/elevator_scheduler_if.sv
// Call-button / car-status bundle between the panel logic and the scheduler.
// The slave side is the scheduler; the master side drives the call buttons.
interface elevator_scheduler_if #(
   parameter int FLOORS = 7
);
   logic [FLOORS-1:0] call_i;
   logic [2:0]        elev_f_o;
   logic [1:0]        dir_o;
   logic              door_open_o;
   logic [FLOORS-1:0] pending_o;
   logic              busy_o;

   modport master (
      output call_i,
      input  elev_f_o, dir_o, door_open_o,
      input  pending_o, busy_o
   );

   modport slave (
      input  call_i,
      output elev_f_o, dir_o, door_open_o,
      output pending_o, busy_o
   );
endinterface

// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator scheduler; owns the car floor (1..FLOORS).
// Optional ELEV_EMERGENCY_STOP_EN adds stop_i, which freezes state and timers.
module elevator_scheduler #(
   parameter int FLOORS     = 7,
   parameter int MOVE_TICKS = 50,
   parameter int DOOR_TICKS = 100
) (
   input logic clk,
   input logic rst_n,
`ifdef ELEV_EMERGENCY_STOP_EN
   input logic stop_i,
`endif
   elevator_scheduler_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_DOWN = 2'd2;
   localparam logic [1:0] S_DOOR = 2'd3;

   localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ?
                         MOVE_TICKS : DOOR_TICKS;
   localparam int CW   = $clog2(MAXT + 1);

   localparam logic [CW-1:0] MOVE_END = CW'(MOVE_TICKS - 1);
   localparam logic [CW-1:0] DOOR_END = CW'(DOOR_TICKS - 1);

   logic [1:0]        state, state_nx;
   logic [2:0]        floor, floor_nx, nf;
   logic [CW-1:0]     cnt, cnt_nx;
   logic              last_up, last_up_nx;
   logic [FLOORS-1:0] pend, clr, req;
   logic [FLOORS-1:0] here_m, nf_m;
   logic              above, below, freeze;

`ifdef ELEV_EMERGENCY_STOP_EN
   assign freeze = stop_i;
`else
   assign freeze = 1'b0;
`endif

   function automatic logic [FLOORS-1:0] onehot(
      input logic [2:0] f
   );
      logic [FLOORS-1:0] m;
      m = '0;
      for (int k = 0; k < FLOORS; k++)
         if (k + 1 == int'(f)) m[k] = 1'b1;
      return m;
   endfunction

   assign req    = pend | bus.call_i;
   assign nf     = (state == S_DOWN) ? floor - 3'd1
                                     : floor + 3'd1;
   assign here_m = onehot(floor);
   assign nf_m   = onehot(nf);

   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int k = 0; k < FLOORS; k++) begin
         if (pend[k] && (k + 1 > int'(floor))) above = 1'b1;
         if (pend[k] && (k + 1 < int'(floor))) below = 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      floor_nx   = floor;
      cnt_nx     = cnt;
      last_up_nx = last_up;
      clr        = '0;
      if (!freeze) begin
         unique case (state)
            S_IDLE: begin
               cnt_nx = '0;
               if (|(pend & here_m)) begin
                  state_nx = S_DOOR;
                  clr      = here_m;
               end else if (above && below) begin
                  state_nx = last_up ? S_UP : S_DOWN;
               end else if (above) begin
                  state_nx   = S_UP;
                  last_up_nx = 1'b1;
               end else if (below) begin
                  state_nx   = S_DOWN;
                  last_up_nx = 1'b0;
               end
            end
            S_UP, S_DOWN: begin
               if (cnt == MOVE_END) begin
                  floor_nx = nf;
                  cnt_nx   = '0;
                  if (|(req & nf_m)) begin
                     state_nx = S_DOOR;
                     clr      = nf_m;
                  end
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            S_DOOR: begin
               // a call at the open floor keeps the door open
               if (|(req & here_m)) begin
                  clr    = here_m;
                  cnt_nx = '0;
               end else if (cnt == DOOR_END) begin
                  cnt_nx = '0;
                  if (last_up ? above : below) begin
                     state_nx = last_up ? S_UP : S_DOWN;
                  end else if (last_up ? below : above) begin
                     state_nx   = last_up ? S_DOWN : S_UP;
                     last_up_nx = ~last_up;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         floor   <= 3'd1;
         cnt     <= '0;
         last_up <= 1'b1;
         pend    <= '0;
      end else begin
         state   <= state_nx;
         floor   <= floor_nx;
         cnt     <= cnt_nx;
         last_up <= last_up_nx;
         pend    <= req & ~clr;
      end
   end

   assign bus.elev_f_o    = floor;
   assign bus.dir_o       = {state == S_DOWN, state == S_UP};
   assign bus.door_open_o = (state == S_DOOR);
   assign bus.busy_o      = (state != S_IDLE);
   assign bus.pending_o   = pend;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler (FLOORS=7, MOVE_TICKS=4, DOOR_TICKS=3).
// Covers reset, same-floor call, travel, SCAN reversal, door retrigger.
module tb_elevator_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   elevator_scheduler_if #(.FLOORS(7)) bus ();

`ifdef ELEV_EMERGENCY_STOP_EN
   logic stop_i = 1'b0;
`endif

   elevator_scheduler #(
      .FLOORS(7),
      .MOVE_TICKS(4),
      .DOOR_TICKS(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef ELEV_EMERGENCY_STOP_EN
      .stop_i(stop_i),
`endif
      .bus(bus)
   );

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input logic [6:0] m);
      bus.call_i = m;
      tick();
      bus.call_i = '0;
   endtask

   initial begin
      bus.call_i = '0;

      // async reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_floor", 8'(bus.elev_f_o), 8'd1);
      chk("rst_dir", 8'(bus.dir_o), 8'd0);
      chk("rst_pend", 8'(bus.pending_o), 8'd0);
      chk("rst_busy", 8'(bus.busy_o), 8'd0);
      chk("rst_door", 8'(bus.door_open_o), 8'd0);
      ticks(2);
      rst_n = 1'b1;
      tick();

      // same-floor call
      press(7'b0000001);
      chk("f1_latch", 8'(bus.pending_o), 8'h01);
      chk("f1_nodoor", 8'(bus.door_open_o), 8'd0);
      tick();
      chk("f1_door", 8'(bus.door_open_o), 8'd1);
      chk("f1_clr", 8'(bus.pending_o), 8'd0);
      chk("f1_busy", 8'(bus.busy_o), 8'd1);
      chk("f1_dir", 8'(bus.dir_o), 8'd0);
      tick();
      chk("f1_door2", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("f1_door3", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("f1_close", 8'(bus.door_open_o), 8'd0);
      chk("f1_idle", 8'(bus.busy_o), 8'd0);

      // travel 1 -> 4
      press(7'b0001000);
      chk("f4_latch", 8'(bus.pending_o), 8'h08);
      tick();
      chk("f4_up", 8'(bus.dir_o), 8'd1);
      chk("f4_start", 8'(bus.elev_f_o), 8'd1);
      for (int f = 2; f <= 4; f++) begin
         ticks(3);
         chk("f4_hold", 8'(bus.elev_f_o), 8'(f - 1));
         tick();
         chk("f4_step", 8'(bus.elev_f_o), 8'(f));
      end
      chk("f4_door", 8'(bus.door_open_o), 8'd1);
      chk("f4_dir0", 8'(bus.dir_o), 8'd0);
      chk("f4_clr", 8'(bus.pending_o), 8'd0);
      ticks(2);
      chk("f4_door3", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("f4_close", 8'(bus.door_open_o), 8'd0);
      chk("f4_idle", 8'(bus.busy_o), 8'd0);

      // SCAN: calls 6 and 2 from floor 4, last direction up
      press(7'b0100010);
      tick();
      chk("scan_up", 8'(bus.dir_o), 8'd1);
      ticks(4);
      chk("scan_f5", 8'(bus.elev_f_o), 8'd5);
      chk("scan_pass5", 8'(bus.door_open_o), 8'd0);
      chk("scan_dir5", 8'(bus.dir_o), 8'd1);
      ticks(4);
      chk("scan_f6", 8'(bus.elev_f_o), 8'd6);
      chk("scan_door6", 8'(bus.door_open_o), 8'd1);
      chk("scan_pend6", 8'(bus.pending_o), 8'h02);
      ticks(3);
      chk("scan_rev", 8'(bus.dir_o), 8'd2);
      chk("scan_rev_f", 8'(bus.elev_f_o), 8'd6);
      for (int f = 5; f >= 2; f--) begin
         ticks(4);
         chk("scan_down", 8'(bus.elev_f_o), 8'(f));
      end
      chk("scan_door2", 8'(bus.door_open_o), 8'd1);
      chk("scan_clr", 8'(bus.pending_o), 8'd0);
      ticks(3);
      chk("scan_idle", 8'(bus.busy_o), 8'd0);

      // door retrigger at floor 4
      press(7'b0001000);
      tick();
      chk("rt_up", 8'(bus.dir_o), 8'd1);
      ticks(8);
      chk("rt_f4", 8'(bus.elev_f_o), 8'd4);
      chk("rt_door", 8'(bus.door_open_o), 8'd1);
      tick();
      bus.call_i = 7'b0001000;
      tick();
      bus.call_i = '0;
      chk("rt_nopend", 8'(bus.pending_o), 8'd0);
      chk("rt_open0", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("rt_open1", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("rt_open2", 8'(bus.door_open_o), 8'd1);
      tick();
      chk("rt_close", 8'(bus.door_open_o), 8'd0);
      chk("rt_pend", 8'(bus.pending_o), 8'd0);

      // reset mid-move aborts and drops calls
      press(7'b1000000);
      tick();
      ticks(5);
      chk("mr_f5", 8'(bus.elev_f_o), 8'd5);
      #3 rst_n = 1'b0;
      #1;
      chk("mr_floor", 8'(bus.elev_f_o), 8'd1);
      chk("mr_dir", 8'(bus.dir_o), 8'd0);
      chk("mr_pend", 8'(bus.pending_o), 8'd0);
      chk("mr_busy", 8'(bus.busy_o), 8'd0);
      ticks(2);
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
